// File: rtl/eth_frame_tx.sv
// eth_frame_tx : byte-serial Ethernet frame transmitter.
//
// Builds one frame per accepted START: 14-byte header (DST, SRC, EtherType),
// LEN payload bytes pulled through pay_req/pay_dat, zero padding up to
// MIN_LEN bytes, an optional 4-byte FCS, then an inter-frame gap of IFG
// byte slots with FRM low. Every byte advance is qualified by tx_cke.
//
// Optional feature: define ETH_TX_FCS_EN to append the CRC-32 FCS. Without
// it the frame ends at the last payload/pad byte and no CRC logic exists.
//
// Ports
//   clk            master clock
//   rst_n          asynchronous active-low reset
//   tx_cke         byte-rate clock enable
//   start          single-cycle request to send one frame
//   dst_mac        destination MAC, captured on START acceptance
//   ethtype        EtherType/length, captured on START acceptance
//   len            payload byte count, captured (clamped to 1500)
//   pay_dat        payload byte, valid whenever pay_req is high
//   pay_req        combinational: payload byte consumed this cycle
//   busy           high from START acceptance until the gap completes
//   out_eth_stream {CKE, FRM, DAT[7:0]} registered output stream
module eth_frame_tx #(
  parameter logic [47:0] SRC_MAC = 48'h00_21_70_9D_2D_4D,
  parameter int          IFG     = 12,
  parameter int          MIN_LEN = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_cke,
  input  logic        start,
  input  logic [47:0] dst_mac,
  input  logic [15:0] ethtype,
  input  logic [10:0] len,
  input  logic [7:0]  pay_dat,
  output logic        pay_req,
  output logic        busy,
  output logic [9:0]  out_eth_stream
);

  typedef enum logic [2:0] {IDLE, HDR, PAY, PAD, FCS, GAP} state_t;

  localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
  localparam logic [10:0] MAX_PAY  = 11'd1500;
  localparam logic [15:0] GAP_LAST = 16'(IFG - 1);

`ifdef ETH_TX_FCS_EN
  localparam state_t POST_DATA = FCS;
`else
  localparam state_t POST_DATA = GAP;
`endif

  state_t      state;
  logic [47:0] dst_q;
  logic [15:0] type_q;
  logic [10:0] len_q;
  logic [10:0] cnt;       // index of the next byte to emit within the frame
  logic [15:0] gap_cnt;
  logic [10:0] pay_end;   // index of the last header/payload byte
  logic [10:0] data_last; // index of the last byte covered by the FCS
  logic        cur_frm;
  logic [7:0]  cur_dat;

  function automatic logic [10:0] clamp_len(input logic [10:0] l);
    return (l > MAX_PAY) ? MAX_PAY : l;
  endfunction

  // Header byte idx of {dst, SRC_MAC, ethtype}, most significant byte first.
  function automatic logic [7:0] hdr_byte(input logic [3:0] idx,
                                          input logic [47:0] d,
                                          input logic [15:0] t);
    logic [111:0] h;
    h = {d, SRC_MAC, t} << {idx, 3'b000};
    return h[111:104];
  endfunction

  assign pay_end   = 11'd13 + len_q;
  assign data_last = (pay_end >= MIN_L - 11'd1) ? pay_end : MIN_L - 11'd1;
  assign pay_req   = tx_cke && (state == PAY);

`ifdef ETH_TX_FCS_EN
  logic [31:0] crc;
  logic        data_emit;
  logic [10:0] fcs_off;

  // Reflected CRC-32 (poly 0x04C11DB7 reversed = 0xEDB88320), one byte.
  function automatic logic [31:0] crc_next(input logic [31:0] c,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h000000, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // FCS byte k is the inverted CRC, least significant byte first.
  function automatic logic [7:0] fcs_byte(input logic [31:0] c,
                                          input logic [1:0] k);
    logic [31:0] s;
    s = ~c >> {k, 3'b000};
    return s[7:0];
  endfunction

  assign data_emit = tx_cke && ((state == IDLE && busy) || state == HDR ||
                                state == PAY || state == PAD);
  assign fcs_off   = cnt - data_last - 11'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      crc <= 32'h0;
    else if (start && !busy)
      crc <= 32'hFFFFFFFF;
    else if (data_emit)
      crc <= crc_next(crc, cur_dat);
  end
`endif

  // Byte presented to the output register on the next enabled edge.
  always_comb begin
    cur_frm = 1'b0;
    cur_dat = 8'h00;
    case (state)
      IDLE: if (busy) begin
        cur_frm = 1'b1;
        cur_dat = hdr_byte(cnt[3:0], dst_q, type_q);
      end
      HDR: begin
        cur_frm = 1'b1;
        cur_dat = hdr_byte(cnt[3:0], dst_q, type_q);
      end
      PAY: begin
        cur_frm = 1'b1;
        cur_dat = pay_dat;
      end
      PAD: cur_frm = 1'b1;
`ifdef ETH_TX_FCS_EN
      FCS: begin
        cur_frm = 1'b1;
        cur_dat = fcs_byte(crc, fcs_off[1:0]);
      end
`endif
      default: ;
    endcase
  end

  // Control FSM and registered output stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      out_eth_stream <= 10'h000;
      dst_q          <= 48'h0;
      type_q         <= 16'h0;
      len_q          <= 11'h0;
      cnt            <= 11'h0;
      gap_cnt        <= 16'h0;
    end else begin
      out_eth_stream[9] <= tx_cke;
      if (tx_cke)
        out_eth_stream[8:0] <= {cur_frm, cur_dat};

      if (start && !busy) begin
        busy    <= 1'b1;
        dst_q   <= dst_mac;
        type_q  <= ethtype;
        len_q   <= clamp_len(len);
        cnt     <= 11'h0;
        gap_cnt <= 16'h0;
      end else if (tx_cke) begin
        case (state)
          IDLE: if (busy) begin
            cnt   <= 11'd1;
            state <= HDR;
          end
          HDR: begin
            cnt <= cnt + 11'd1;
            if (cnt == 11'd13) begin
              if (cnt == data_last)  state <= POST_DATA;
              else if (len_q != 0)   state <= PAY;
              else                   state <= PAD;
            end
          end
          PAY: begin
            cnt <= cnt + 11'd1;
            if (cnt == pay_end)
              state <= (cnt == data_last) ? POST_DATA : PAD;
          end
          PAD: begin
            cnt <= cnt + 11'd1;
            if (cnt == data_last)
              state <= POST_DATA;
          end
`ifdef ETH_TX_FCS_EN
          FCS: begin
            cnt <= cnt + 11'd1;
            if (cnt == data_last + 11'd4)
              state <= GAP;
          end
`endif
          GAP: begin
            gap_cnt <= gap_cnt + 16'd1;
            if (gap_cnt == GAP_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= 11'h0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_tx.sv
// tb_eth_frame_tx : self-checking bench for eth_frame_tx.
// Expected frames are built byte by byte from the frame layout (header,
// payload, zero pad, optional FCS) and compared with the captured stream.
module tb_eth_frame_tx;

  localparam int          IFG     = 12;
  localparam int          MIN_LEN = 60;
  localparam logic [47:0] SRC     = 48'h00_21_70_9D_2D_4D;
`ifdef ETH_TX_FCS_EN
  localparam int FCS_BYTES = 4;
`else
  localparam int FCS_BYTES = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_cke = 1'b0;
  logic        start = 1'b0;
  logic [47:0] dst_mac = 48'h0;
  logic [15:0] ethtype = 16'h0;
  logic [10:0] len = 11'h0;
  logic [7:0]  pay_dat = 8'h00;
  logic        pay_req;
  logic        busy;
  logic [9:0]  out_eth_stream;

  eth_frame_tx #(.SRC_MAC(SRC), .IFG(IFG), .MIN_LEN(MIN_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .tx_cke(tx_cke), .start(start),
    .dst_mac(dst_mac), .ethtype(ethtype), .len(len), .pay_dat(pay_dat),
    .pay_req(pay_req), .busy(busy), .out_eth_stream(out_eth_stream)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] pay_arr [0:2047];
  logic [7:0] rx [$];
  int   pidx, npayreq, gapcnt, dat_err, hold_err, cke_err, frm_loads;
  int   cyc = 0;
  int   cke_mode = 0;
  logic cke_sent, busy_before, consume;
  logic [9:0] prev_out = 10'h0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_ref(input logic [31:0] c,
                                          input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ b[i]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
      else                       r = r >> 1;
    end
    return r;
  endfunction

  // One clock cycle: drive tx_cke/pay_dat, pass the edge, sample at negedge.
  task automatic step();
    case (cke_mode)
      0:       tx_cke = 1'b1;
      1:       tx_cke = (cyc % 4 == 0);
      default: tx_cke = ($urandom_range(0, 2) != 0);
    endcase
    cke_sent    = tx_cke;
    busy_before = busy;
    #1;
    pay_dat = pay_arr[pidx];
    consume = pay_req;
    if (pay_req) npayreq++;
    @(posedge clk);
    cyc++;
    if (consume) pidx++;
    @(negedge clk);
    start = 1'b0;
    if (out_eth_stream[9] !== cke_sent) cke_err++;
    if (!cke_sent && out_eth_stream[8:0] !== prev_out[8:0]) hold_err++;
    if (cke_sent) begin
      if (out_eth_stream[8]) begin
        rx.push_back(out_eth_stream[7:0]);
        frm_loads++;
      end else begin
        if (out_eth_stream[7:0] != 8'h00) dat_err++;
        if (busy_before && rx.size() > 0) gapcnt++;
      end
    end
    prev_out = out_eth_stream;
  endtask

  task automatic idle_steps(input int n, input string tag);
    int f0;
    f0 = frm_loads;
    cke_mode = 0;
    for (int i = 0; i < n; i++) step();
    check({tag, "_no_frame"}, frm_loads - f0, 0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic run_frame(input string tag, input logic [47:0] d,
                           input logic [15:0] et, input logic [10:0] l,
                           input int mode, input int rst_pay, input bit inject);
    logic [7:0]  exp [$];
    logic [31:0] c;
    int eff, nbad, to, aborted;
    eff = (l > 11'd1500) ? 1500 : int'(l);
    for (int i = 0; i < eff; i++) pay_arr[i] = 8'($urandom);
    exp.delete();
    for (int i = 0; i < 6; i++) exp.push_back(d[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) exp.push_back(SRC[8*(5-i) +: 8]);
    exp.push_back(et[15:8]);
    exp.push_back(et[7:0]);
    for (int i = 0; i < eff; i++) exp.push_back(pay_arr[i]);
    while (exp.size() < MIN_LEN) exp.push_back(8'h00);
`ifdef ETH_TX_FCS_EN
    c = 32'hFFFFFFFF;
    foreach (exp[i]) c = crc_ref(c, exp[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) exp.push_back(c[8*i +: 8]);
`endif
    rx.delete();
    pidx = 0; npayreq = 0; gapcnt = 0; dat_err = 0; hold_err = 0; cke_err = 0;
    cke_mode = mode;
    dst_mac = d; ethtype = et; len = l; start = 1'b1;
    step();
    check({tag, "_busy_set"}, busy, 1'b1);
    dst_mac = {$urandom, 16'($urandom)};
    ethtype = 16'($urandom);
    len     = 11'($urandom);
    to = 1; aborted = 0;
    for (int n = 0; n < 20000; n++) begin
      if (inject && (pidx == 10 || gapcnt == 3)) start = 1'b1;
      step();
      if (rst_pay >= 0 && pidx == rst_pay) begin
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_rst_out"}, out_eth_stream, 10'h000);
        check({tag, "_rst_busy"}, busy, 1'b0);
        aborted = 1; to = 0;
        break;
      end
      if (!busy) begin
        to = 0;
        break;
      end
    end
    start = 1'b0;
    if (to != 0) check({tag, "_timeout"}, 1, 0);
    if (aborted == 0 && to == 0) begin
      check({tag, "_nbytes"}, rx.size(), exp.size());
      nbad = 0;
      foreach (exp[i]) if (i >= rx.size() || rx[i] !== exp[i]) nbad++;
      check({tag, "_bytes"}, nbad, 0);
      check({tag, "_payreq"}, npayreq, eff);
      check({tag, "_gap"}, gapcnt, IFG);
      check({tag, "_dat0"}, dat_err, 0);
      check({tag, "_hold"}, hold_err, 0);
      check({tag, "_cke9"}, cke_err, 0);
`ifdef ETH_TX_FCS_EN
      c = 32'hFFFFFFFF;
      foreach (rx[i]) c = crc_ref(c, rx[i]);
      check({tag, "_residue"}, c, 32'hDEBB20E3);
`endif
    end
  endtask

  initial begin
    frm_loads = 0; pidx = 0;
    for (int i = 0; i < 2048; i++) pay_arr[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_out", out_eth_stream, 10'h000);
    check("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    prev_out = out_eth_stream;

    run_frame("bcast46", 48'hFF_FF_FF_FF_FF_FF, 16'h0800, 11'd46, 0, -1, 1'b0);
    check("bcast46_count", rx.size(), 60 + FCS_BYTES);
    check("bcast46_src0", rx[6], 8'h00);
    check("bcast46_src5", rx[11], 8'h4D);

    run_frame("len0", 48'h02_11_22_33_44_55, 16'h88B5, 11'd0, 0, -1, 1'b0);
    check("len0_count", rx.size(), 60 + FCS_BYTES);

    run_frame("div4", 48'h0A_0B_0C_0D_0E_0F, 16'h86DD, 11'd100, 1, -1, 1'b0);
    check("div4_count", rx.size(), 114 + FCS_BYTES);

    run_frame("dbl", 48'h12_34_56_78_9A_BC, 16'h0806, 11'd80, 0, -1, 1'b1);
    idle_steps(30, "dbl_after");

    run_frame("midrst", 48'hAA_BB_CC_DD_EE_FF, 16'h0800, 11'd60, 0, 20, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_out = out_eth_stream;
    idle_steps(20, "post_rst");
    run_frame("rst_next", 48'h66_55_44_33_22_11, 16'h0800, 11'd64, 2, -1, 1'b0);

    run_frame("len1500", 48'h00_11_22_33_44_55, 16'h0800, 11'd1500, 0, -1, 1'b0);
    check("len1500_count", rx.size(), 1514 + FCS_BYTES);

    run_frame("clamp", 48'h00_AA_00_BB_00_CC, 16'h0800, 11'd1700, 0, -1, 1'b0);

    for (int k = 0; k < 5; k++)
      run_frame("rand", {$urandom, 16'($urandom)}, 16'($urandom),
                11'($urandom_range(0, 120)), $urandom_range(0, 2), -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_frame_tx.md
ETH_FRAME_TX -- requirements
Module: eth_frame_tx

Interface
REQ-001 Parameter SRC_MAC, default 48'h00_21_70_9D_2D_4D: source MAC inserted at frame bytes 6-11.
REQ-002 Parameter IFG, default 12: inter-frame gap, in CKE cycles with FRM low.
REQ-003 Parameter MIN_LEN, default 60: minimum frame length before FCS, in bytes.
REQ-004 CLK  input  1  master clock; single clock domain.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 TX_CKE  input  1  byte-rate clock enable; all byte advances occur only on CLK edges with TX_CKE=1.
REQ-007 START  input  1  request to send one frame; single-cycle pulse.
REQ-008 DST_MAC  input  48  destination MAC; sampled when START is accepted.
REQ-009 ETHTYPE  input  16  EtherType/length field; sampled when START is accepted.
REQ-010 LEN  input  11  payload byte count; sampled when START is accepted.
REQ-011 PAY_DAT  input  8  payload byte; must be valid in any cycle where PAY_REQ=1.
REQ-012 PAY_REQ  output  1  combinational; =1 when TX_CKE=1 and state is PAY; PAY_DAT is consumed in that cycle.
REQ-013 BUSY  output  1  registered; high from START acceptance until the IFG has completed.
REQ-014 OUT_ETH_STREAM  output  10  registered stream: bit 9 CKE, bit 8 FRM, bits 7:0 DAT.

Function
REQ-015 The block SHALL accept START only when BUSY=0; on acceptance, set BUSY=1 and capture DST_MAC, ETHTYPE and LEN (LEN>1500 clamped to 1500).
REQ-016 The block SHALL ignore START while BUSY=1, with no queuing.
REQ-017 States SHALL be IDLE, HDR, PAY, PAD, FCS and GAP; each transition occurs only on a TX_CKE=1 edge.
REQ-018 IDLE with an accepted request: on the next TX_CKE=1 edge emit byte 0 and enter HDR.
REQ-019 HDR SHALL emit 14 bytes in order: DST_MAC[47:40] first, then SRC_MAC MSB first, then ETHTYPE[15:8], ETHTYPE[7:0].
REQ-020 PAY SHALL emit exactly LEN bytes of PAY_DAT.
- LEN=0: PAY is skipped entirely; PAY_REQ never asserts.
REQ-021 PAD SHALL emit 8'h00 bytes until bytes emitted = MIN_LEN.
- PAD is skipped when 14+LEN >= MIN_LEN.
REQ-022 After PAD/PAY: enter FCS when ETH_TX_FCS_EN is defined, else enter GAP.
REQ-023 GAP SHALL hold FRM=0 for IFG TX_CKE cycles, then enter IDLE and clear BUSY on the same edge.
REQ-024 Every CLK edge: OUT_ETH_STREAM[9] <= TX_CKE.
- TX_CKE=1 edges: bits 8:0 load the current {FRM, DAT}.
- TX_CKE=0 edges: bits 8:0 hold.
REQ-025 FRM SHALL be 1 continuously from the first header byte through the last FCS/pad byte; DAT is 8'h00 whenever FRM=0.
REQ-026 Byte counter SHALL be 11 bits, saturating only at frame end; no wrap within a frame.

Reset
REQ-027 RST_N=0 SHALL immediately force: state IDLE, BUSY=0, OUT_ETH_STREAM=10'h000, counters and CRC cleared, captured fields cleared.
REQ-028 Reset mid-frame SHALL truncate the frame (FRM drops asynchronously).
- After release, the first frame requires a new START; no gap is inserted.

Configuration
REQ-029 With macro ETH_TX_FCS_EN defined, the block SHALL append a 4-byte FCS after the last payload/pad byte.
- CRC-32: reflected polynomial 0x04C11DB7, init 32'hFFFFFFFF, final inversion.
- Computed over bytes 0..end of pad; transmitted least-significant byte first.
REQ-030 Without ETH_TX_FCS_EN, the block SHALL contain no CRC logic and the frame SHALL end at the last payload/pad byte.

Verification
REQ-031 TX_CKE=1 constantly, LEN=46, ETHTYPE=16'h0800, DST_MAC=48'hFF_FF_FF_FF_FF_FF -> 60 FRM bytes (64 with FCS):
- bytes 0-5 = FF;
- bytes 6-11 = 00 21 70 9D 2D 4D;
- bytes 12-13 = 08 00;
- 12 FRM=0 cycles, then BUSY=0.
REQ-032 LEN=0 -> PAY_REQ never asserts; 14 header bytes, then 46 bytes of 00.
REQ-033 TX_CKE high one cycle in four, LEN=100 -> exactly 114 FRM bytes.
- OUT_ETH_STREAM[9] follows TX_CKE delayed by one cycle.
- bits 8:0 change only after TX_CKE=1 cycles.
REQ-034 Second START issued during PAY and again during GAP -> both ignored; exactly one frame emitted.
REQ-035 RST_N pulsed low at payload byte 20 -> OUT_ETH_STREAM=0 and BUSY=0 immediately; a new START then produces a complete, correct frame.
REQ-036 ETH_TX_FCS_EN defined, LEN=1500 -> 1518 bytes.
- Running reflected CRC register, before final inversion, over all bytes including the FCS = 32'hDEBB20E3.
